// File: rtl/zbus_defs.sv
// zbus_defs: shared defaults, register offsets and decode/arming helpers for the zbus slave.
package zbus_defs;

    localparam logic [7:0]  ZB_IO_BASE  = 8'h20;
    localparam logic [7:0]  ZB_IO_MASK  = 8'hF8;
    localparam logic [15:0] ZB_MEM_BASE = 16'h3F00;
    localparam int          ZB_REG_AW   = 3;

    localparam logic CH_IDLE = 1'b0;
    localparam logic CH_BUSY = 1'b1;

    typedef enum logic [2:0] {
        REG_CTRL = 3'd0,
        REG_STAT = 3'd1,
        REG_TXD  = 3'd2,
        REG_RXD  = 3'd3,
        REG_ADDR = 3'd4,
        REG_EP   = 3'd5,
        REG_IRQ  = 3'd6,
        REG_CFG  = 3'd7
    } reg_off_e;

    function automatic logic io_hit(input logic [7:0] a, input logic [7:0] base, input logic [7:0] mask);
        return ((a ^ base) & mask) == 8'h00;
    endfunction

    // Busy stays set until a genuine inactive sample reaches s1; the synchronizer's
    // reset value is not a real sample, hence the live qualifier.
    function automatic logic busy_next(input logic s1, input logic s2, input logic busy, input logic live);
        return (s1 & s2) | (busy & (s1 | !live));
    endfunction

endpackage

// File: rtl/zbus_sync.sv
// zbus_sync: two-flop synchronizer with a parameterized reset value.
module zbus_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s1,
    output logic s2
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

endmodule

// File: rtl/zbus_slave.sv
// zbus_slave: Z80 I/O bus slave producing clk-synchronous register strobes.
// Define ZBUS_MEMWIN_EN to also decode the MEM_BASE memory window.
module zbus_slave
    import zbus_defs::*;
#(
    parameter logic [7:0]  IO_BASE  = ZB_IO_BASE,
    parameter logic [7:0]  IO_MASK  = ZB_IO_MASK,
    parameter int          REG_AW   = ZB_REG_AW,
    parameter logic [15:0] MEM_BASE = ZB_MEM_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       z_a,
    inout  wire  [7:0]        z_d,
    input  logic              z_mreq_n,
    input  logic              z_iorq_n,
    input  logic              z_rd_n,
    input  logic              z_wr_n,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr_stb,
    output logic [REG_AW-1:0] reg_rd_addr,
    input  logic [7:0]        reg_rdata,
    output logic              reg_rd_stb
);

    logic io_sel, mem_sel, wr_req, rd_req;
    logic ws1, ws2, rs1, rs2;
    logic live, w_busy, r_busy, r_act;
    logic w_start, r_start, r_end;

    assign io_sel = !z_iorq_n & z_mreq_n & io_hit(z_a[7:0], IO_BASE, IO_MASK);
`ifdef ZBUS_MEMWIN_EN
    assign mem_sel = !z_mreq_n & z_iorq_n & (z_a[15:8] == MEM_BASE[15:8]);
`else
    // Tied off; the compare only keeps MEM_BASE and the high address bits referenced.
    assign mem_sel = 1'b0 & (z_a[15:8] == MEM_BASE[15:8]);
`endif

    assign wr_req      = (io_sel | mem_sel) & !z_wr_n & z_rd_n;
    assign rd_req      = (io_sel | mem_sel) & !z_rd_n & z_wr_n;
    assign z_d         = rd_req ? reg_rdata : 8'hzz;
    assign reg_rd_addr = z_a[REG_AW-1:0];

    zbus_sync #(.RST_VAL(CH_IDLE)) u_wr_sync (.clk(clk), .rst_n(rst_n), .d(wr_req), .s1(ws1), .s2(ws2));
    zbus_sync #(.RST_VAL(CH_IDLE)) u_rd_sync (.clk(clk), .rst_n(rst_n), .d(rd_req), .s1(rs1), .s2(rs2));

    assign w_start = ws1 & ws2 & !w_busy;
    assign r_start = rs1 & rs2 & !r_busy;
    assign r_end   = r_act & rs2 & !rs1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live       <= 1'b0;
            w_busy     <= CH_BUSY;
            r_busy     <= CH_BUSY;
            r_act      <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;
        end else begin
            live       <= 1'b1;
            w_busy     <= busy_next(ws1, ws2, w_busy, live);
            r_busy     <= busy_next(rs1, rs2, r_busy, live);
            r_act      <= r_start | (r_act & !r_end);
            reg_wr_stb <= w_start;
            reg_rd_stb <= r_end;
            if (w_start) begin
                reg_addr  <= z_a[REG_AW-1:0];
                reg_wdata <= z_d;
            end
        end
    end

endmodule
